// File: rtl/tpu_tile_sequencer_pkg.sv
// Shared types for the TPU tile sequencer: FSM states, VPU modes and the latched tile command.
package tpu_pkg;

   // Widths of the latched command record; the sequencer defaults its parameters to these.
   localparam int TILE_ADDR_WIDTH  = 10;
   localparam int TILE_ARRAY_WIDTH = 16;

   typedef enum logic [2:0] {
      IDLE,
      LOAD_W,
      SETTLE,
      COMPUTE,
      DRAIN,
      DONE
   } seq_state_t;

   typedef enum logic [2:0] {
      VPU_PASS      = 3'd0,
      VPU_RELU      = 3'd1,
      VPU_BIAS      = 3'd2,
      VPU_BIAS_RELU = 3'd3,
      VPU_QUANT     = 3'd4
   } vpu_mode_t;

   typedef struct packed {
      logic [TILE_ADDR_WIDTH-1:0]  a_base;
      logic [TILE_ADDR_WIDTH-1:0]  b_base;
      logic [TILE_ADDR_WIDTH-1:0]  c_base;
      logic [TILE_ADDR_WIDTH-1:0]  d_base;
      logic [TILE_ADDR_WIDTH-1:0]  m_rows;
      logic [2:0]                  vpu_mode;
      logic [TILE_ARRAY_WIDTH-1:0] row_mask;
      logic [TILE_ARRAY_WIDTH-1:0] col_mask;
   } tile_cmd_t;

endpackage

// File: rtl/tpu_sched_delay_line.sv
// Fixed-latency shift register carrying {valid,data}; occupied is high while any stage holds a valid entry.
module tpu_sched_delay_line #(
   parameter int DEPTH = 16,
   parameter int WIDTH = 10
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data,
   output logic             occupied
);

   logic [DEPTH-1:0] vld;
   logic [WIDTH-1:0] dat [DEPTH];

   always_ff @(posedge clk) begin
      if (rst) begin
         vld <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) dat[i] <= '0;
      end else begin
         vld    <= {vld[DEPTH-2:0], in_valid};
         dat[0] <= in_data;
         for (int unsigned i = 1; i < DEPTH; i++) dat[i] <= dat[i-1];
      end
   end

   assign out_valid = vld[DEPTH-1];
   assign out_data  = dat[DEPTH-1];
   assign occupied  = |vld;

endmodule

// File: rtl/tpu_tile_sequencer.sv
// Tile sequencer for tpu_core: loads weights, streams input rows, schedules bias reads
// through a latency-matched delay line and counts write-backs until the tile completes.
module tpu_tile_sequencer
   import tpu_pkg::*;
#(
   parameter int SYSTOLIC_ARRAY_WIDTH = TILE_ARRAY_WIDTH,
   parameter int ADDR_WIDTH           = TILE_ADDR_WIDTH,
   parameter int SYS_LATENCY          = 16,
   parameter int W_SETTLE             = 16,
   parameter int DRAIN_TIMEOUT        = 1024
) (
   input  logic                                    clk,
   input  logic                                    rst,
   input  logic                                    cmd_valid,
   output logic                                    cmd_ready,
   input  logic [ADDR_WIDTH-1:0]                   cmd_a_base,
   input  logic [ADDR_WIDTH-1:0]                   cmd_b_base,
   input  logic [ADDR_WIDTH-1:0]                   cmd_c_base,
   input  logic [ADDR_WIDTH-1:0]                   cmd_d_base,
   input  logic [ADDR_WIDTH-1:0]                   cmd_m_rows,
   input  logic [2:0]                              cmd_vpu_mode,
   input  logic [SYSTOLIC_ARRAY_WIDTH-1:0]         cmd_row_mask,
   input  logic [SYSTOLIC_ARRAY_WIDTH-1:0]         cmd_col_mask,
   output logic [ADDR_WIDTH-1:0]                   ctrl_rd_addr_a,
   output logic [ADDR_WIDTH-1:0]                   ctrl_rd_addr_b,
   output logic [ADDR_WIDTH-1:0]                   ctrl_rd_addr_c,
   output logic                                    ctrl_rd_en_a,
   output logic                                    ctrl_rd_en_b,
   output logic                                    ctrl_rd_en_c,
   output logic                                    ctrl_a_valid,
   output logic                                    ctrl_a_switch,
   output logic                                    ctrl_b_accept_w,
   output logic [$clog2(SYSTOLIC_ARRAY_WIDTH)-1:0] ctrl_b_weight_index,
   output logic                                    ctrl_c_valid,
   output logic [2:0]                              ctrl_vpu_mode,
   output logic [SYSTOLIC_ARRAY_WIDTH-1:0]         ctrl_row_mask,
   output logic [SYSTOLIC_ARRAY_WIDTH-1:0]         ctrl_col_mask,
   output logic [ADDR_WIDTH-1:0]                   ctrl_wr_addr_d,
   input  logic                                    core_writeback_valid,
   output logic                                    busy,
   output logic                                    done,
   output logic                                    err
);

   localparam int CW = ADDR_WIDTH + 1;
   localparam int WI = $clog2(SYSTOLIC_ARRAY_WIDTH);
   localparam int TW = $clog2(DRAIN_TIMEOUT) + 1;
   localparam logic [CW-1:0] W_LAST  = CW'(SYSTOLIC_ARRAY_WIDTH - 1);
   localparam logic [CW-1:0] S_LAST  = CW'(W_SETTLE - 1);
   localparam logic [TW-1:0] TO_LAST = TW'(DRAIN_TIMEOUT - 1);

   seq_state_t            state, state_nxt;
   tile_cmd_t             cmd_q;
   logic [CW-1:0]         cnt;
   logic [ADDR_WIDTH-1:0] wb_cnt;
   logic [TW-1:0]         idle_cnt;
   logic [ADDR_WIDTH-1:0] m_last;
   logic [ADDR_WIDTH-1:0] bias_row;
   logic                  accept, cnt_last, wb_live, wb_full, timeout, line_busy;

   assign accept  = cmd_valid && cmd_ready;
   assign m_last  = cmd_q.m_rows - ADDR_WIDTH'(1);
   assign wb_live = core_writeback_valid && (state == COMPUTE || state == DRAIN);
   assign wb_full = (wb_cnt == cmd_q.m_rows);
   assign timeout = (state == DRAIN) && !core_writeback_valid && (idle_cnt == TO_LAST);

   always_comb begin
      cnt_last = 1'b0;
      case (state)
         LOAD_W:  cnt_last = (cnt == W_LAST);
         SETTLE:  cnt_last = (cnt == S_LAST);
         COMPUTE: cnt_last = (cnt[ADDR_WIDTH-1:0] == m_last);
         default: cnt_last = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept) state_nxt = (cmd_m_rows == '0) ? DONE : LOAD_W;
         LOAD_W:  if (cnt_last) state_nxt = SETTLE;
         SETTLE:  if (cnt_last) state_nxt = COMPUTE;
         COMPUTE: if (cnt_last) state_nxt = DRAIN;
         DRAIN:   if (timeout || (wb_full && !line_busy)) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      cmd_ready    = (state == IDLE);
      busy         = (state != IDLE);
      done         = (state == DONE);
      ctrl_rd_en_b = (state == LOAD_W);
      ctrl_rd_en_a = (state == COMPUTE);
   end

   // Shared phase counter: weight row, settle tick or input row depending on state.
   always_ff @(posedge clk) begin
      if (rst || state != state_nxt)                     cnt <= '0;
      else if (state inside {LOAD_W, SETTLE, COMPUTE}) cnt <= cnt + CW'(1);
      else                                               cnt <= '0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cmd_q               <= '0;
         wb_cnt              <= '0;
         idle_cnt            <= '0;
         err                 <= 1'b0;
         ctrl_a_valid        <= 1'b0;
         ctrl_a_switch       <= 1'b0;
         ctrl_b_accept_w     <= 1'b0;
         ctrl_b_weight_index <= '0;
         ctrl_c_valid        <= 1'b0;
      end else begin
         ctrl_a_valid        <= ctrl_rd_en_a;
         ctrl_a_switch       <= ctrl_rd_en_a && (cnt == '0);
         ctrl_b_accept_w     <= ctrl_rd_en_b;
         ctrl_b_weight_index <= ctrl_rd_en_b ? cnt[WI-1:0] : '0;
         ctrl_c_valid        <= ctrl_rd_en_c;
         if (accept) begin
            cmd_q  <= '{a_base: cmd_a_base, b_base: cmd_b_base, c_base: cmd_c_base,
                        d_base: cmd_d_base, m_rows: cmd_m_rows, vpu_mode: cmd_vpu_mode,
                        row_mask: cmd_row_mask, col_mask: cmd_col_mask};
            wb_cnt <= '0;
            err    <= 1'b0;
         end
         // Surplus write-backs flag the tile but leave the address parked at d_base+M.
         if (wb_live) begin
            if (wb_full) err    <= 1'b1;
            else         wb_cnt <= wb_cnt + ADDR_WIDTH'(1);
         end
         if (state != DRAIN || core_writeback_valid) idle_cnt <= '0;
         else                                         idle_cnt <= idle_cnt + TW'(1);
         if (timeout) err <= 1'b1;
      end
   end

   tpu_sched_delay_line #(
      .DEPTH (SYS_LATENCY),
      .WIDTH (ADDR_WIDTH)
   ) u_bias_line (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (ctrl_rd_en_a),
      .in_data   (cnt[ADDR_WIDTH-1:0]),
      .out_valid (ctrl_rd_en_c),
      .out_data  (bias_row),
      .occupied  (line_busy)
   );

   assign ctrl_rd_addr_a = cmd_q.a_base + cnt[ADDR_WIDTH-1:0];
   assign ctrl_rd_addr_b = cmd_q.b_base + cnt[ADDR_WIDTH-1:0];
   assign ctrl_rd_addr_c = cmd_q.c_base + bias_row;
   assign ctrl_wr_addr_d = cmd_q.d_base + wb_cnt;
   assign ctrl_vpu_mode  = cmd_q.vpu_mode;
   assign ctrl_row_mask  = cmd_q.row_mask;
   assign ctrl_col_mask  = cmd_q.col_mask;

endmodule

// File: tb/tb_tpu_tile_sequencer.sv
// Randomized bench for tpu_tile_sequencer; expected per-cycle behaviour comes from a tile-level timing model.
module tb_tpu_tile_sequencer;

   localparam int W      = 16;
   localparam int AW     = 10;
   localparam int LAT    = 16;
   localparam int SET    = 16;
   localparam int TMO    = 1024;
   localparam int NT     = 14;
   localparam int MAXCYC = 20000;
   localparam int NEVER  = 32'h3fff_ffff;
   localparam int PAST   = -1000000;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          cmd_valid = 1'b0;
   logic          cmd_ready;
   logic [AW-1:0] cmd_a_base = '0, cmd_b_base = '0, cmd_c_base = '0, cmd_d_base = '0, cmd_m_rows = '0;
   logic [2:0]    cmd_vpu_mode = '0;
   logic [W-1:0]  cmd_row_mask = '0, cmd_col_mask = '0;
   logic [AW-1:0] ctrl_rd_addr_a, ctrl_rd_addr_b, ctrl_rd_addr_c, ctrl_wr_addr_d;
   logic          ctrl_rd_en_a, ctrl_rd_en_b, ctrl_rd_en_c;
   logic          ctrl_a_valid, ctrl_a_switch, ctrl_b_accept_w, ctrl_c_valid;
   logic [3:0]    ctrl_b_weight_index;
   logic [2:0]    ctrl_vpu_mode;
   logic [W-1:0]  ctrl_row_mask, ctrl_col_mask;
   logic          core_writeback_valid = 1'b0;
   logic          busy, done, err;

   always #5 clk = ~clk;

   tpu_tile_sequencer #(
      .SYSTOLIC_ARRAY_WIDTH (W),
      .ADDR_WIDTH           (AW),
      .SYS_LATENCY          (LAT),
      .W_SETTLE             (SET),
      .DRAIN_TIMEOUT        (TMO)
   ) dut (
      .clk (clk), .rst (rst),
      .cmd_valid (cmd_valid), .cmd_ready (cmd_ready),
      .cmd_a_base (cmd_a_base), .cmd_b_base (cmd_b_base), .cmd_c_base (cmd_c_base),
      .cmd_d_base (cmd_d_base), .cmd_m_rows (cmd_m_rows), .cmd_vpu_mode (cmd_vpu_mode),
      .cmd_row_mask (cmd_row_mask), .cmd_col_mask (cmd_col_mask),
      .ctrl_rd_addr_a (ctrl_rd_addr_a), .ctrl_rd_addr_b (ctrl_rd_addr_b), .ctrl_rd_addr_c (ctrl_rd_addr_c),
      .ctrl_rd_en_a (ctrl_rd_en_a), .ctrl_rd_en_b (ctrl_rd_en_b), .ctrl_rd_en_c (ctrl_rd_en_c),
      .ctrl_a_valid (ctrl_a_valid), .ctrl_a_switch (ctrl_a_switch),
      .ctrl_b_accept_w (ctrl_b_accept_w), .ctrl_b_weight_index (ctrl_b_weight_index),
      .ctrl_c_valid (ctrl_c_valid), .ctrl_vpu_mode (ctrl_vpu_mode),
      .ctrl_row_mask (ctrl_row_mask), .ctrl_col_mask (ctrl_col_mask),
      .ctrl_wr_addr_d (ctrl_wr_addr_d), .core_writeback_valid (core_writeback_valid),
      .busy (busy), .done (done), .err (err)
   );

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;
   int started = 0;
   int reset_chk = 1;

   // Current tile as seen by the model: fields plus its event timeline.
   int cur_t0, cur_ta, cur_done, cur_err, cur_abort, cur_extra, cur_seen;
   int cur_a, cur_b, cur_c, cur_d, cur_m, cur_mode, cur_rm, cur_cm;
   int cur_wbs[$];

   // Command held on the pins until the sequencer can take it.
   bit pend_v = 1'b0;
   int pend_kind, pend_a, pend_b, pend_c, pend_d, pend_m, pend_mode, pend_rm, pend_cm;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
      end
   endtask

   // 0 random, 1 surplus write-back, 2 silent drain, 3 reset mid-compute, 4 address wrap, 5 empty, 6 fixed example
   function automatic int kind_of(input int idx);
      case (idx)
         0: return 6;   1: return 5;   3: return 1;   5: return 3;
         6: return 4;   8: return 2;  10: return 5;  11: return 1;
         default: return 0;
      endcase
   endfunction

   task automatic set_null();
      cur_t0 = PAST; cur_ta = PAST; cur_done = PAST; cur_err = NEVER;
      cur_abort = -1; cur_extra = -1; cur_seen = 0;
      cur_a = 0; cur_b = 0; cur_c = 0; cur_d = 0; cur_m = 0;
      cur_mode = 0; cur_rm = 0; cur_cm = 0;
      cur_wbs.delete();
   endtask

   task automatic make_pend(input int idx);
      pend_kind = kind_of(idx);
      pend_a = $urandom_range(0, 1023); pend_b = $urandom_range(0, 1023);
      pend_c = $urandom_range(0, 1023); pend_d = $urandom_range(0, 1023);
      pend_m = $urandom_range(1, 8);
      pend_mode = $urandom_range(0, 7);
      pend_rm = $urandom_range(0, 65535); pend_cm = $urandom_range(0, 65535);
      case (pend_kind)
         2: pend_m = $urandom_range(1, 4);
         3: pend_m = 5;
         4: begin pend_a = 1020; pend_b = 1015; pend_c = 1022; pend_d = 1021; pend_m = 6; end
         5: pend_m = 0;
         6: begin pend_b = 8; pend_a = 20; pend_c = 40; pend_d = 1023; pend_m = 3; end
         default: ;
      endcase
      pend_v = 1'b1;
   endtask

   task automatic present_pend();
      cmd_valid    = 1'b1;
      cmd_a_base   = AW'(pend_a); cmd_b_base = AW'(pend_b);
      cmd_c_base   = AW'(pend_c); cmd_d_base = AW'(pend_d);
      cmd_m_rows   = AW'(pend_m); cmd_vpu_mode = 3'(pend_mode);
      cmd_row_mask = W'(pend_rm); cmd_col_mask = W'(pend_cm);
   endtask

   task automatic accept_pend();
      int tc, lw, w;
      cur_a = pend_a; cur_b = pend_b; cur_c = pend_c; cur_d = pend_d; cur_m = pend_m;
      cur_mode = pend_mode; cur_rm = pend_rm; cur_cm = pend_cm;
      cur_t0 = cyc; cur_seen = 0; cur_extra = -1; cur_abort = -1; cur_err = NEVER;
      cur_wbs.delete();
      if (cur_m == 0) begin
         cur_ta = cyc + 1; cur_done = cyc + 1;
      end else begin
         cur_ta = cyc + 1 + W + SET;
         tc = cur_ta + cur_m - 1 + LAT;
         if (pend_kind == 2) begin
            cur_done = cur_ta + cur_m + TMO; cur_err = cur_done;
         end else if (pend_kind == 3) begin
            cur_done = NEVER; cur_abort = cur_ta + 1;
         end else begin
            lw = -1;
            for (int r = 0; r < cur_m; r++) begin
               w = cur_ta + r + LAT + 1 + $urandom_range(0, 3);
               if (w <= lw) w = lw + 1;
               cur_wbs.push_back(w);
               lw = w;
            end
            cur_done = ((tc + 1 > lw + 1) ? tc + 1 : lw + 1) + 1;
            if (pend_kind == 1) begin
               cur_extra = lw + 1; cur_done = lw + 2; cur_err = lw + 2;
            end
         end
      end
      pend_v = 1'b0;
      started++;
   endtask

   task automatic check_cycle();
      int k, ra;
      logic e_busy, e_b, e_aw, e_a, e_av, e_sw, e_c, e_cv, e_err;
      logic [63:0] exp_fields;
      e_busy = (cyc >= cur_t0 + 1) && (cyc <= cur_done);
      k      = cyc - (cur_t0 + 1);
      e_b    = (cur_m > 0) && (k >= 0) && (k < W);
      e_aw   = (cur_m > 0) && (k >= 1) && (k <= W);
      e_a    = (cyc >= cur_ta) && (cyc < cur_ta + cur_m);
      e_av   = (cyc >= cur_ta + 1) && (cyc <= cur_ta + cur_m);
      e_sw   = (cur_m > 0) && (cyc == cur_ta + 1);
      e_c    = (cyc >= cur_ta + LAT) && (cyc < cur_ta + LAT + cur_m);
      e_cv   = (cyc >= cur_ta + LAT + 1) && (cyc <= cur_ta + LAT + cur_m);
      e_err  = (cyc >= cur_err);
      check("flags",
            64'({cmd_ready, busy, done, err, ctrl_rd_en_a, ctrl_rd_en_b, ctrl_rd_en_c,
                 ctrl_a_valid, ctrl_a_switch, ctrl_b_accept_w, ctrl_c_valid}),
            64'({!e_busy, e_busy, (cyc == cur_done), e_err, e_a, e_b, e_c, e_av, e_sw, e_aw, e_cv}));
      if (e_b)  check("rd_addr_b", 64'(ctrl_rd_addr_b), 64'((cur_b + k) % 1024));
      if (e_aw) check("weight_index", 64'(ctrl_b_weight_index), 64'(k - 1));
      if (e_a)  check("rd_addr_a", 64'(ctrl_rd_addr_a), 64'((cur_a + cyc - cur_ta) % 1024));
      if (e_c)  check("rd_addr_c", 64'(ctrl_rd_addr_c), 64'((cur_c + cyc - cur_ta - LAT) % 1024));
      if ((cur_wbs.size() > 0 && cur_wbs[0] == cyc) || cyc == cur_extra) begin
         ra = (cur_seen < cur_m) ? cur_seen : cur_m;
         check("wr_addr_d", 64'(ctrl_wr_addr_d), 64'((cur_d + ra) % 1024));
      end
      exp_fields = (64'(cur_mode) << 32) | (64'(cur_rm) << 16) | 64'(cur_cm);
      check("latched_fields", 64'({ctrl_vpu_mode, ctrl_row_mask, ctrl_col_mask}), exp_fields);
      if (cyc == reset_chk)
         check("reset_addrs", 64'({ctrl_rd_addr_a, ctrl_rd_addr_b, ctrl_rd_addr_c,
                                   ctrl_wr_addr_d, ctrl_b_weight_index}), 64'(0));
   endtask

   task automatic drive();
      bit idle;
      rst = 1'b0;
      core_writeback_valid = 1'b0;
      if (cyc == cur_abort) begin
         rst = 1'b1; cmd_valid = 1'b0; pend_v = 1'b0;
         set_null();
         reset_chk = cyc + 1;
         return;
      end
      idle = (cyc > cur_done);
      if (idle) begin
         if (!pend_v && started < NT) make_pend(started);
         if (pend_v) begin
            present_pend();
            accept_pend();
         end else begin
            cmd_valid = 1'b0;
         end
      end else if (!pend_v && started < NT && $urandom_range(0, 7) == 0) begin
         make_pend(started);
         present_pend();
      end
      if (cur_wbs.size() > 0 && cur_wbs[0] == cyc) begin
         core_writeback_valid = 1'b1;
         void'(cur_wbs.pop_front());
         cur_seen++;
      end else if (cyc == cur_extra) begin
         core_writeback_valid = 1'b1;
      end else if (idle || (cyc >= cur_t0 + 1 && cyc < cur_ta)) begin
         core_writeback_valid = ($urandom_range(0, 3) == 0);
      end
   endtask

   initial begin
      bit finished;
      set_null();
      finished = 1'b0;
      while (!finished) begin
         @(negedge clk);
         if (cyc >= 1) check_cycle();
         if (cyc < 2) rst = 1'b1;
         else         drive();
         if (started == NT && cur_abort < 0 && cyc > cur_done + 3) finished = 1'b1;
         if (!finished && cyc >= MAXCYC) begin
            check("cycle_budget", 64'(started), 64'(NT + 1));
            finished = 1'b1;
         end
         cyc++;
      end
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
